sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the basic fifo block.
//  Adds arbitrary (non-power-of-2) depth, occupancy output, programmable
//  almost-full/almost-empty thresholds and sticky overflow/underflow errors.
//  Sits between a producer and consumer in one clock domain; optional
//  first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  WIDTH      8  data word width in bits (>=1)
//  DEPTH      8  number of entries (>=2, need not be a power of 2)
//  AF_THRESH  6  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2  almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                    clock, rising edge
//  arst_n        in   1                    async reset, active low
//  wr_en         in   1                    push request
//  data_in       in   WIDTH                push data
//  rd_en         in   1                    pop request
//  data_out      out  WIDTH                pop data
//  full          out  1                    count == DEPTH
//  empty         out  1                    count == 0
//  almost_full   out  1                    count >= AF_THRESH
//  almost_empty  out  1                    count <= AE_THRESH
//  count         out  $clog2(DEPTH+1)      current occupancy
//  overflow      out  1                    sticky: write attempted while full
//  underflow     out  1                    sticky: read attempted while empty
//  clr_err       in   1                    sync clear of overflow/underflow
// BEHAVIOUR
//  - One clock clk; reset arst_n asynchronous, active-low. While low: write_ptr,
//    read_ptr, count, data_out, overflow, underflow = 0; empty=1, full=0,
//    almost_empty=1, almost_full=0. Memory contents not reset.
//  - Reset mid-operation discards all stored data; first cycle after release
//    behaves as freshly empty.
//  - Write accepted iff wr_en && !full; mem[write_ptr] <= data_in.
//  - Read accepted iff rd_en && !empty; evaluated on pre-edge state.
//  - Both accepted same cycle: count unchanged, both pointers advance.
//  - Full with wr_en&&rd_en: read accepted, write rejected, overflow set.
//  - Empty with wr_en&&rd_en: write accepted, read rejected, underflow set.
//  - Pointers width $clog2(DEPTH); advance p==DEPTH-1 -> 0, else p+1.
//  - count +1 on write-only, -1 on read-only; never exceeds DEPTH / below 0.
//  - All flags derived combinationally from registered count.
//  - Rejected write/read: pointers, count, memory, data_out unchanged.
//  - overflow/underflow set at edge after illegal request; clr_err clears
//    them; set wins over clr_err in the same cycle.
//  - Standard mode: data_out registered, = mem[read_ptr] one cycle after an
//    accepted read; holds last value otherwise.
// CONFIGURATION
//  FIFO_FWFT_EN defined: data_out = mem[read_ptr] combinationally whenever
//    !empty (head visible with no rd_en, zero read latency); rd_en pops head;
//    data_out = 0 while empty. Write to empty FIFO visible next cycle.
//  FIFO_FWFT_EN undefined: standard registered mode above.
//  Flags, count and error behaviour identical in both modes.
// TESTING (WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1)
//  1. Assert arst_n=0 -> empty=1, almost_empty=1, full=0, count=0,
//     data_out=0x00, overflow=underflow=0.
//  2. Write 0x11,0x22,0x33,0x44,0x55 -> count 1..5, almost_full=1 at count=4,
//     full=1 at 5; write 0x66 -> overflow=1, count=5, contents unchanged.
//  3. Read 5 times -> data_out 0x11..0x55 one cycle after each rd_en; 6th
//     rd_en -> underflow=1, data_out holds 0x55; clr_err -> both errors 0.
//  4. Loop write 3/read 3 four times -> pointers wrap 4->0, 12 words out in
//     order, count returns to 0.
//  5. Simultaneous wr_en+rd_en at count=2 -> count stays 2; at full -> count
//     5->4, overflow=1; at empty -> count 0->1, underflow=1.
//  6. Async reset asserted mid-burst at count=3 -> all outputs to reset
//     values immediately; next write 0x77 then read returns 0x77.
//  7. FIFO_FWFT_EN: write 0xA5 to empty -> next cycle data_out=0xA5,
//     empty=0 with no rd_en; rd_en pops, data_out=0x00, empty=1.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy, threshold flags and sticky errors
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered data_out.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // An illegal request in the same cycle as clr_err keeps the error set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && full)       overflow_d = 1'b1;
        else if (clr_err)        overflow_d = 1'b0;
        if (rd_en && empty)      underflow_d = 1'b1;
        else if (clr_err)        underflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) data_out_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) data_out_q <= '0;
        else         data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
